vga_scaler: RTL and testbench

- Sits directly downstream of the VGA timing generator, between the capture front-end and the DVI/VGA output pins.
- Takes a low-resolution source pixel stream (default 160x144, 2 bpp) into a two-line ping-pong buffer.
- Emits each source pixel as a SCALE x SCALE block, centred in the 640x480 active area, with a border colour outside the window.
- Delays hs/vs/enable so sync and pixels stay aligned at the output.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_line_buf.sv | 35 +++
 rtl/vga_scaler.sv | 209 ++++++++++++++++++++
 tb/tb_vga_scaler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants and types for the VGA scaler slice.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACT   = 640;
    localparam int V_ACT   = 480;
    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int                     PIX_W_DEF  = 2;
    localparam logic [PIX_W_DEF-1:0]   BORDER_DEF = '0;
    localparam logic [PIX_W_DEF-1:0]   UNDER_DEF  = '1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_buf
// Description : Two-bank line store, one write and one synchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_line_buf #(
    parameter int COL_W = 8,
    parameter int PIX_W = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [COL_W:0]   i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic [COL_W:0]   i_raddr,
    output logic [PIX_W-1:0] o_rdata
);

    localparam int c_DEPTH = 2 ** (COL_W + 1);

    // Address is {bank, column}; the array carries no reset.
    logic [PIX_W-1:0] r_mem [0:c_DEPTH-1];
    logic [PIX_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : vga_line_buf
`default_nettype wire

// File: rtl/vga_scaler.sv
`default_nettype none
// ============================================================================
// Module      : vga_scaler
// Description : Replicates a low-res pixel stream into a centred 640x480 window.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scaler
    import vga_pkg::*;
#(
    parameter int               SRC_W  = 160,
    parameter int               SRC_H  = 144,
    parameter int               SCALE  = 3,
    parameter int               X_OFF  = 80,
    parameter int               Y_OFF  = 24,
    parameter int               PIX_W  = PIX_W_DEF,
    parameter logic [PIX_W-1:0] BORDER = '0,
    parameter logic [PIX_W-1:0] UNDER  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_sof,
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_data,
    output logic             src_ready,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             enable_in,
    input  logic [10:0]      x_in,
    input  logic [10:0]      y_in,
    output logic [PIX_W-1:0] pix_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             de_out,
    output logic             underflow
);

    localparam int COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int DIV_W = $clog2(SCALE + 1);

    localparam coord_t c_X_LO = coord_t'(X_OFF);
    localparam coord_t c_X_HI = coord_t'(X_OFF + SRC_W * SCALE);
    localparam coord_t c_Y_LO = coord_t'(Y_OFF);
    localparam coord_t c_Y_HI = coord_t'(Y_OFF + SRC_H * SCALE);

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(SRC_W - 1);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(SCALE - 1);

    generate
        if (X_OFF + SRC_W * SCALE > H_ACT) begin : g_chk_x
            $error("vga_scaler: window wider than the active area");
        end
        if (Y_OFF + SRC_H * SCALE > V_ACT) begin : g_chk_y
            $error("vga_scaler: window taller than the active area");
        end
        if (SCALE < 2 || SCALE > 4) begin : g_chk_scale
            $error("vga_scaler: SCALE must be within 2..4");
        end
    endgenerate

    // Write side
    logic [COL_W-1:0] r_wcol;
    logic             r_wbank;
    logic [1:0]       r_full;
    logic [1:0]       w_full_nxt;
    logic             w_accept;
    logic             w_wlast;

    // Read side
    logic [DIV_W-1:0] r_xdiv;
    logic [DIV_W-1:0] r_ydiv;
    logic [COL_W-1:0] r_rcol;
    logic             r_rbank;
    logic             w_in_win;
    logic             w_xlast;
    logic             w_line_end;
    logic             w_rlast;
    logic             w_vs_fall;

    // Pipeline
    sync_t            r_sync1;
    sync_t            r_sync2;
    logic             r_win1;
    logic             r_starve1;
    logic [PIX_W-1:0] r_pix;
    logic             r_underflow;
    logic [PIX_W-1:0] w_rdata;

    assign src_ready = !r_full[r_wbank];
    assign w_accept  = src_valid && src_ready && !src_sof;
    assign w_wlast   = w_accept && (r_wcol == c_COL_LAST);

    always_ff @(posedge clk) begin
        if (rst || src_sof) begin
            r_wcol  <= '0;
            r_wbank <= 1'b0;
        end else if (w_accept) begin
            if (w_wlast) begin
                r_wcol  <= '0;
                r_wbank <= ~r_wbank;
            end else begin
                r_wcol  <= r_wcol + 1'b1;
            end
        end
    end

    // The set is applied last so a same-bank collision leaves the bank full.
    always_comb begin
        w_full_nxt = r_full;
        if (src_sof) begin
            w_full_nxt = 2'b00;
        end
        if (w_rlast) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
        if (w_wlast) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    assign w_in_win = enable_in
                   && (x_in >= c_X_LO) && (x_in < c_X_HI)
                   && (y_in >= c_Y_LO) && (y_in < c_Y_HI);

    // r_sync1.vs is vs_in from the previous cycle, reused as the edge detector.
    assign w_vs_fall  = r_sync1.vs && !vs_in;
    assign w_xlast    = (r_xdiv == c_DIV_LAST);
    assign w_line_end = w_in_win && w_xlast && (r_rcol == c_COL_LAST);
    assign w_rlast    = w_line_end && (r_ydiv == c_DIV_LAST) && !w_vs_fall;

    // Source row tracking is implicit in the bank handshake, so no row counter.
    always_ff @(posedge clk) begin
        if (rst || w_vs_fall) begin
            r_xdiv  <= '0;
            r_rcol  <= '0;
            r_ydiv  <= '0;
            r_rbank <= 1'b0;
        end else begin
            if (w_in_win) begin
                if (w_xlast) begin
                    r_xdiv <= '0;
                    r_rcol <= (r_rcol == c_COL_LAST) ? '0 : r_rcol + 1'b1;
                end else begin
                    r_xdiv <= r_xdiv + 1'b1;
                end
            end
            if (w_line_end) begin
                if (r_ydiv == c_DIV_LAST) begin
                    r_ydiv  <= '0;
                    r_rbank <= ~r_rbank;
                end else begin
                    r_ydiv  <= r_ydiv + 1'b1;
                end
            end
        end
    end

    vga_line_buf #(
        .COL_W (COL_W),
        .PIX_W (PIX_W)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr ({r_wbank, r_wcol}),
        .i_wdata (src_data),
        .i_raddr ({r_rbank, r_rcol}),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= SYNC_IDLE;
            r_win1    <= 1'b0;
            r_starve1 <= 1'b0;
        end else begin
            r_sync1   <= '{hs: hs_in, vs: vs_in, de: enable_in};
            r_win1    <= w_in_win;
            r_starve1 <= w_in_win && !r_full[r_rbank];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync2     <= SYNC_IDLE;
            r_pix       <= BORDER;
            r_underflow <= 1'b0;
        end else begin
            r_sync2     <= r_sync1;
            r_pix       <= !r_win1    ? BORDER :
                           r_starve1  ? UNDER  : w_rdata;
            r_underflow <= r_starve1 || (r_underflow && !(r_sync2.vs && !r_sync1.vs));
        end
    end

    assign pix_out   = r_pix;
    assign hs_out    = r_sync2.hs;
    assign vs_out    = r_sync2.vs;
    assign de_out    = r_sync2.de;
    assign underflow = r_underflow;

endmodule : vga_scaler
`default_nettype wire

// File: tb/tb_vga_scaler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scaler
// Description : Randomised bench for vga_scaler against a line-FIFO reference.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_scaler;

    localparam int SRC_W = 160;
    localparam int SCALE = 3;
    localparam int X_LO  = 80;
    localparam int X_HI  = 80 + SRC_W * SCALE;
    localparam int Y_LO  = 24;
    localparam int Y_HI  = 24 + 144 * SCALE;

    typedef logic [2*SRC_W-1:0] line_t;
    typedef struct {
        logic [1:0] pix;
        logic       hs;
        logic       vs;
        logic       de;
        logic       uf;
        bit         dir;
        logic [1:0] rexp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_sof;
    logic        src_valid;
    logic [1:0]  src_data;
    logic        src_ready;
    logic        hs_in;
    logic        vs_in;
    logic        enable_in;
    logic [10:0] x_in;
    logic [10:0] y_in;
    logic [1:0]  pix_out;
    logic        hs_out;
    logic        vs_out;
    logic        de_out;
    logic        underflow;

    always #5 clk = ~clk;

    vga_scaler dut (
        .clk       (clk),
        .rst       (rst),
        .src_sof   (src_sof),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .enable_in (enable_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .pix_out   (pix_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .de_out    (de_out),
        .underflow (underflow)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: completed source lines waiting to be shown, oldest first.
    line_t done_q[$];
    line_t cur;
    int    wcnt;
    int    m_lines;
    int    wline;
    logic  m_vs_prev;
    logic  m_vsout_prev;
    logic  m_uf;
    exp_t  eq[$];
    bit    ramp_en;
    bit    dir_en;

    task automatic step(input bit sof, input int vm, input logic hs, input logic vs,
                        input logic en, input int x, input int y);
        exp_t  e;
        exp_t  got;
        line_t fl;
        bit    win;
        bit    starve;
        bit    do_pop;
        logic  v;
        logic [1:0] d;
        int    n_before;

        @(negedge clk);
        got = eq.pop_front();
        chk("out", {got.pix, got.hs, got.vs, got.de, got.uf},
                   {pix_out, hs_out, vs_out, de_out, underflow});
        if (got.dir) chk("ramp", pix_out, got.rexp);
        chk("ready", src_ready, (done_q.size() < 2));

        v = (vm == 2) ? 1'b1 : (vm == 1) ? ($urandom_range(3) != 0) : 1'b0;
        d = (ramp_en && m_lines == 0) ? 2'(wcnt % 4) : 2'($urandom_range(3));
        src_sof   = sof;
        src_valid = v;
        src_data  = d;
        hs_in     = hs;
        vs_in     = vs;
        enable_in = en;
        x_in      = 11'(x);
        y_in      = 11'(y);

        n_before = done_q.size();
        win    = en && x >= X_LO && x < X_HI && y >= Y_LO && y < Y_HI;
        starve = win && (n_before == 0);
        if (!win) begin
            e.pix = 2'b00;
        end else if (starve) begin
            e.pix = 2'b11;
        end else begin
            fl    = done_q[0];
            e.pix = fl[((x - X_LO) / SCALE) * 2 +: 2];
        end
        e.hs = hs;
        e.vs = vs;
        e.de = en;
        if (starve) m_uf = 1'b1;
        else if (m_vsout_prev && !vs) m_uf = 1'b0;
        e.uf = m_uf;
        m_vsout_prev = vs;
        e.dir  = dir_en && y >= 24 && y <= 26 &&
                 (x == 79 || x == 80 || x == 82 || x == 83 || x == 85 ||
                  x == 557 || x == 559 || x == 560);
        e.rexp = (x < X_LO || x >= X_HI) ? 2'b00 : 2'(((x - X_LO) / SCALE) % 4);
        eq.push_back(e);

        do_pop = 1'b0;
        if (m_vs_prev && !vs) begin
            wline = 0;
        end else if (win && x == X_HI - 1) begin
            do_pop = (wline % SCALE == SCALE - 1) && (n_before > 0);
            wline++;
        end
        m_vs_prev = vs;

        if (sof) begin
            done_q.delete();
            wcnt    = 0;
            m_lines = 0;
        end else if (v && n_before < 2) begin
            cur[wcnt*2 +: 2] = d;
            wcnt++;
            if (wcnt == SRC_W) begin
                done_q.push_back(cur);
                wcnt = 0;
                m_lines++;
            end
        end
        if (do_pop) void'(done_q.pop_front());
    endtask

    task automatic line(input int y, input int vm);
        for (int x = 0; x < 656; x++) begin
            step(1'b0, vm, !(x >= 648 && x < 652), 1'b1, (x < 640 && y < 480), x, y);
        end
    endtask

    task automatic frame_start();
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, (i >= 3), 1'b0, 0, 490);
        step(1'b1, 2, 1'b1, 1'b1, 1'b0, 0, 490);
    endtask

    initial begin
        exp_t idle;
        bit   mid;

        rst = 1'b1; src_sof = 1'b0; src_valid = 1'b0; src_data = '0;
        hs_in = 1'b1; vs_in = 1'b1; enable_in = 1'b0; x_in = '0; y_in = '0;
        wcnt = 0; m_lines = 0; wline = 0; cur = '0;
        m_vs_prev = 1'b1; m_vsout_prev = 1'b1; m_uf = 1'b0;
        ramp_en = 1'b0; dir_en = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pix",   pix_out,   2'b00);
        chk("rst_hs",    hs_out,    1'b1);
        chk("rst_vs",    vs_out,    1'b1);
        chk("rst_de",    de_out,    1'b0);
        chk("rst_ready", src_ready, 1'b1);
        chk("rst_uf",    underflow, 1'b0);
        rst = 1'b0;
        idle = '{pix: 2'b00, hs: 1'b1, vs: 1'b1, de: 1'b0, uf: 1'b0, dir: 1'b0, rexp: 2'b00};
        eq.push_back(idle);
        eq.push_back(idle);

        // Ramp line first, then backpressure while reads drain the banks.
        ramp_en = 1'b1;
        dir_en  = 1'b1;
        frame_start();
        line(0, 1);
        line(23, 1);
        for (int y = 24; y <= 32; y++) line(y, 1);
        line(470, 1);
        ramp_en = 1'b0;
        dir_en  = 1'b0;

        // Starved window line, flag held until vs_out falls.
        frame_start();
        line(24, 0);
        line(470, 0);

        // Restart in the middle of a line.
        frame_start();
        mid = 1'b0;
        for (int x = 0; x < 656; x++) begin
            if (!mid && wcnt == 50) begin
                step(1'b1, 2, 1'b1, 1'b1, (x < 640), x, 0);
                mid = 1'b1;
            end else begin
                step(1'b0, (mid && m_lines >= 1) ? 0 : 1, 1'b1, 1'b1, (x < 640), x, 0);
            end
        end
        for (int y = 24; y <= 29; y++) line(y, 1);

        for (int f = 0; f < 2; f++) begin
            frame_start();
            line(0, 1);
            line(23, 1);
            for (int y = 24; y <= 29; y++) line(y, 1);
            line(456, 1);
        end
        frame_start();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_vga_scaler
`default_nettype wire
